booth_mult_sequencer: RTL and testbench
=======================================

# booth_mult_sequencer

Sequential radix-4 Booth multiplier datapath for the processor's multdiv unit. It is the consumer end of the Booth control interface. Each cycle it presents the 3-bit Booth window from its multiplier register and receives the decoded same/sub/shift flags from the Booth control decoder. It accumulates the selected partial product and shifts, producing a 32-bit signed product with an overflow flag and a one-cycle ready pulse.

## Interface
- WIDTH, 32, operand/result width; must be even; iterations = WIDTH/2
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ctrl_MULT  in  1  start pulse; samples operands on the same edge
- data_operandA  in  WIDTH  signed multiplicand M
- data_operandB  in  WIDTH  signed multiplier Q
- booth_bits  out  3  Booth window {Q[1], Q[0], q_m1}; bit 2 is the most significant
- booth_same  in  1  from decoder: window 000/111, add zero
- booth_sub  in  1  from decoder: subtract the selected multiple
- booth_shift  in  1  from decoder: select 2M instead of M
- data_result  out  WIDTH  low WIDTH bits of the product; held until the next start
- data_exception  out  1  signed overflow; held with data_result
- data_resultRDY  out  1  one-cycle pulse when the result is valid

## Operation
- Registers:
  - acc: WIDTH+2 bits, signed
  - mq: WIDTH bits, holds the multiplier
  - q_m1: 1 bit
  - mcand: WIDTH bits
  - cnt: log2(WIDTH/2) bits
  - state
- booth_bits is combinational from {mq[1], mq[0], q_m1}. The decoder closes the loop combinationally within the same cycle.
- Addend selection:
  - booth_same → 0
  - else if booth_shift → sign-extended mcand<<1
  - else → sign-extended mcand
  - if booth_sub and not same → two's-complement negate
  - All arithmetic is WIDTH+2 bits wide, with no carry out.
- Each RUN cycle:
  - sum = acc + addend
  - {acc, mq, q_m1} ← arithmetic right shift by 2 of {sum, mq, q_m1}, sign-filling from sum's MSB
- After WIDTH/2 iterations, the product is the 2·WIDTH-bit value {acc[WIDTH-1:0], mq}.
- data_result = mq.
- data_exception = 1 unless acc[WIDTH+1:0] and mq[WIDTH-1] are all identical (the upper WIDTH+1 bits of the product must equal the sign of the result).
- States:
  - IDLE: on ctrl_MULT, load mcand←A, mq←B, acc←0, q_m1←0, cnt←0 → RUN.
  - RUN: iterate; cnt++. When cnt = WIDTH/2−1 → DONE.
  - DONE: update data_result and data_exception, pulse data_resultRDY → IDLE.
- ctrl_MULT in RUN or DONE restarts: reload operands, cnt←0, → RUN. No ready pulse for the aborted operation. data_result and data_exception keep their previous values.
- ctrl_MULT in DONE still completes the capture and pulse for the finished operation on that edge, then restarts.

## Timing
- Start sampled at edge 0. RUN occupies edges 1..16 (WIDTH=32). The DONE edge is edge 17. data_resultRDY is high for the cycle after edge 17.
- Throughput: one operation per 18 cycles. Back-to-back: ctrl_MULT asserted in the RDY cycle starts immediately.
- Reset (asynchronous, any time including mid-RUN):
  - state IDLE
  - all registers 0
  - data_result 0
  - data_exception 0
  - data_resultRDY 0
  - booth_bits 000
- Decoder flags must settle within the cycle. There is no pipeline register between booth_bits and the flags.

## Structure
- Shared package booth_pkg:
  - state enum IDLE/RUN/DONE
  - MULT_WIDTH=32
  - MULT_ITERS=MULT_WIDTH/2
  - window-width constant 3
- One natural sub-module: booth_addend_select (combinational: mcand, same, sub, shift → WIDTH+2-bit addend).
- The Booth control decoder is instantiated beside this block, not inside it.

## Test plan
- 3 × 5 with pulsed ctrl_MULT → data_result=15, exception=0, RDY one cycle after edge 17, single pulse.
- −7 × 6 → result 0xFFFFFFD6 (−42), exception=0; booth_bits on the first RUN cycle = 100 (B=0b110, q_m1=0).
- 0x7FFFFFFF × 2 → result 0xFFFFFFFE, exception=1. 0x80000000 × −1 → result 0x80000000, exception=1. 65536 × 65536 → result 0, exception=1.
- −1 × −1 and 0x80000000 × 1 → results 1 and 0x80000000, exception=0 for both.
- Assert reset_n low at RUN iteration 8 → all outputs 0 immediately (asynchronous). No RDY pulse follows. A new start after release gives the correct result.
- Restart at RUN iteration 5 with 4 × 4 → no pulse for the first operation. RDY 17 cycles after the restart edge with result=16. The prior data_result is held until then.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier datapath.
package booth_pkg;

  localparam int unsigned MULT_WIDTH  = 32;
  localparam int unsigned MULT_ITERS  = MULT_WIDTH / 2;
  localparam int unsigned BOOTH_WIN_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_addend_select.sv
// Picks the Booth partial product (0, +/-M, +/-2M) from the decoder flags.
module booth_addend_select #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_mcand,
  input  logic             i_same,
  input  logic             i_sub,
  input  logic             i_shift,
  output logic [WIDTH+1:0] o_addend
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0] w_m1;
  logic [AW-1:0] w_m2;
  logic [AW-1:0] w_sel;

  assign w_m1 = {{2{i_mcand[WIDTH-1]}}, i_mcand};
  assign w_m2 = {i_mcand[WIDTH-1], i_mcand, 1'b0};

  always_comb begin
    w_sel = '0;
    if (!i_same) begin
      w_sel = i_shift ? w_m2 : w_m1;
    end
  end

  // Negation is skipped for "same" windows so that 111 never yields -0 artefacts.
  assign o_addend = (i_sub && !i_same) ? (~w_sel + AW'(1)) : w_sel;

endmodule

// File: rtl/booth_mult_sequencer.sv
// Sequential radix-4 Booth multiplier: one 2-bit step per cycle, external window decoder.
module booth_mult_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ctrl_MULT,
  input  logic [WIDTH-1:0]       data_operandA,
  input  logic [WIDTH-1:0]       data_operandB,
  output logic [BOOTH_WIN_W-1:0] booth_bits,
  input  logic                   booth_same,
  input  logic                   booth_sub,
  input  logic                   booth_shift,
  output logic [WIDTH-1:0]       data_result,
  output logic                   data_exception,
  output logic                   data_resultRDY
);

  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned ITERS = (WIDTH == MULT_WIDTH) ? MULT_ITERS : WIDTH / 2;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mq;
  logic             r_q_m1;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_sum;
  logic             w_last;
  logic             w_ovf;

  booth_addend_select #(
    .WIDTH (WIDTH)
  ) u_addend (
    .i_mcand  (r_mcand),
    .i_same   (booth_same),
    .i_sub    (booth_sub),
    .i_shift  (booth_shift),
    .o_addend (w_addend)
  );

  assign booth_bits = {r_mq[1], r_mq[0], r_q_m1};
  assign w_sum      = r_acc + w_addend;
  assign w_last     = (r_cnt == CNT_W'(ITERS - 1));

  // Product fits in WIDTH bits only if every bit above the result matches its sign.
  assign w_ovf = !((&{r_acc, r_mq[WIDTH-1]}) || !(|{r_acc, r_mq[WIDTH-1]}));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mq        <= '0;
      r_q_m1      <= 1'b0;
      r_mcand     <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;

      // A finished operation is always reported, even if a new start lands on the same edge.
      if (r_state == DONE) begin
        r_result    <= r_mq;
        r_exception <= w_ovf;
        r_rdy       <= 1'b1;
      end

      if (ctrl_MULT) begin
        r_mcand <= data_operandA;
        r_mq    <= data_operandB;
        r_acc   <= '0;
        r_q_m1  <= 1'b0;
        r_cnt   <= '0;
        r_state <= RUN;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          RUN: begin
            r_acc  <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
            r_mq   <= {w_sum[1:0], r_mq[WIDTH-1:2]};
            r_q_m1 <= r_mq[1];
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Directed-vector bench for booth_mult_sequencer with a behavioural Booth window decoder.
module tb_booth_mult_sequencer;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [2:0]  booth_bits;
  logic        booth_same;
  logic        booth_sub;
  logic        booth_shift;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_err = 0;
  int n_rdy = 0;
  logic [31:0] last_res = 32'h0;

  booth_mult_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .booth_bits     (booth_bits),
    .booth_same     (booth_same),
    .booth_sub      (booth_sub),
    .booth_shift    (booth_shift),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference Booth control decoder living beside the datapath.
  always_comb begin
    booth_same  = (booth_bits == 3'b000) || (booth_bits == 3'b111);
    booth_sub   = booth_bits[2] && !booth_same;
    booth_shift = (booth_bits == 3'b011) || (booth_bits == 3'b100);
  end

  always @(negedge clock) if (data_resultRDY) n_rdy++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on the negedge just after the start edge; returns edges until RDY (0 on timeout).
  task automatic wait_rdy(input logic [31:0] held, output int n, output bit held_ok);
    n = 0;
    held_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        n = i;
        break;
      end
      if (data_result !== held) held_ok = 1'b0;
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e,
                          output logic [2:0] bits0);
    int  n;
    bit  held_ok;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    @(negedge clock);
    bits0 = booth_bits;
    wait_rdy(last_res, n, held_ok);
    check_val({tag, "_latency"}, 32'(n), 32'd17);
    check_val({tag, "_held"}, 32'(held_ok), 32'd1);
    check_val({tag, "_result"}, data_result, exp_r);
    check_val({tag, "_exc"}, 32'(data_exception), 32'(exp_e));
    last_res = exp_r;
  endtask

  initial begin
    logic [2:0] bits0;
    int         rdy_base;
    int         n;
    bit         held_ok;

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    repeat (3) @(negedge clock);
    check_val("rst_result", data_result, 32'h0);
    check_val("rst_exc", 32'(data_exception), 32'h0);
    check_val("rst_rdy", 32'(data_resultRDY), 32'h0);
    check_val("rst_bits", 32'(booth_bits), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    rdy_base = n_rdy;
    run_mult("3x5", 32'd3, 32'd5, 32'd15, 1'b0, bits0);
    @(negedge clock);
    check_val("3x5_pulse_width", 32'(data_resultRDY), 32'h0);
    @(negedge clock);
    check_val("3x5_pulse_count", 32'(n_rdy - rdy_base), 32'd1);

    run_mult("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, bits0);
    check_val("m7x6_bits0", 32'(bits0), 32'b100);

    run_mult("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, bits0);
    // Back-to-back: each start is driven in the previous RDY cycle.
    run_mult("minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, bits0);
    run_mult("64kx64k", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, bits0);
    run_mult("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, bits0);
    run_mult("minx1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, bits0);
    run_mult("1000xm3", 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_F448, 1'b0, bits0);
    run_mult("maxx2b", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, bits0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clock);
    data_operandA = 32'd12345;
    data_operandB = 32'd678;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_result", data_result, 32'h0);
    check_val("arst_exc", 32'(data_exception), 32'h0);
    check_val("arst_rdy", 32'(data_resultRDY), 32'h0);
    check_val("arst_bits", 32'(booth_bits), 32'h0);
    rdy_base = n_rdy;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check_val("arst_no_pulse", 32'(n_rdy - rdy_base), 32'h0);
    last_res = 32'h0;
    run_mult("post_rst_3x5", 32'd3, 32'd5, 32'd15, 1'b0, bits0);

    // Restart at RUN iteration 5: the aborted operation must never report.
    @(negedge clock);
    rdy_base      = n_rdy;
    data_operandA = 32'd100;
    data_operandB = 32'd100;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd4;
    data_operandB = 32'd4;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    @(negedge clock);
    wait_rdy(32'd15, n, held_ok);
    check_val("restart_latency", 32'(n), 32'd17);
    check_val("restart_held", 32'(held_ok), 32'd1);
    check_val("restart_result", data_result, 32'd16);
    check_val("restart_exc", 32'(data_exception), 32'h0);
    repeat (3) @(negedge clock);
    check_val("restart_pulse_count", 32'(n_rdy - rdy_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
